// File: rtl/phy_tx_serializer.sv
// -----------------------------------------------------------------------------
// phy_tx_serializer
//
// Transmit-side PHY serializer. Four 8-bit lanes each own a one-byte buffer.
// The buffered bytes are multiplexed round-robin (lane 0,1,2,3,0,...) into a
// single byte stream that leaves MSB-first on data_out, one bit per clk_32f.
// After reset the block first emits four COM characters (the first one is the
// byte reset itself loads). After that it fills each lane slot with the lane's
// buffered byte, or with IDLE when that lane's buffer is empty.
//
// Ports
//   clk_32f               in   bit clock, all state updates on its rising edge
//   rst                   in   synchronous reset, active-high
//   data_in_0..3   [7:0]  in   lane bytes
//   valid_in_0..3         in   lane byte offered
//   ready_0..3            out  lane buffer empty (accept = valid_in && ready)
//   data_out              out  serial bit, MSB-first, straight from a flop
//   tx_active             out  high once the COM preamble has been sent
// -----------------------------------------------------------------------------
module phy_tx_serializer #(
  parameter logic [7:0] COM  = 8'hBC,
  parameter logic [7:0] IDLE = 8'h7C
) (
  input  logic       clk_32f,
  input  logic       rst,
  input  logic [7:0] data_in_0,
  input  logic [7:0] data_in_1,
  input  logic [7:0] data_in_2,
  input  logic [7:0] data_in_3,
  input  logic       valid_in_0,
  input  logic       valid_in_1,
  input  logic       valid_in_2,
  input  logic       valid_in_3,
  output logic       ready_0,
  output logic       ready_1,
  output logic       ready_2,
  output logic       ready_3,
  output logic       data_out,
  output logic       tx_active
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Registers
  state_t          r_state;
  logic [7:0]      r_sr;
  logic [2:0]      r_bit_cnt;
  logic [1:0]      r_com_cnt;
  logic [1:0]      r_lane_cnt;
  logic [3:0][7:0] r_buf;
  logic [3:0]      r_full;

  // Combinational
  state_t          w_state_nxt;
  logic [3:0][7:0] w_data_in;
  logic [3:0]      w_valid;
  logic [3:0]      w_accept;
  logic [3:0]      w_consume;
  logic            w_load;
  logic            w_serve;
  logic            w_com_inc;
  logic [7:0]      w_slot_byte;
  logic [7:0]      w_load_byte;

  assign w_data_in = {data_in_3, data_in_2, data_in_1, data_in_0};
  assign w_valid   = {valid_in_3, valid_in_2, valid_in_1, valid_in_0};

  // A full lane never accepts, so accept and consume are disjoint per lane.
  assign w_accept  = w_valid & ~r_full;

  // Byte boundary: the edge that ends bit 7 loads the next byte.
  assign w_load    = (r_bit_cnt == 3'd7);

  // Candidate byte for the lane currently being served.
  assign w_slot_byte = r_full[r_lane_cnt] ? r_buf[r_lane_cnt] : IDLE;

  // ---------------------------------------------------------------------------
  // FSM: next state and byte selection
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path through
    // the block can leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    w_serve     = 1'b0;
    w_com_inc   = 1'b0;
    w_load_byte = COM;
    w_consume   = '0;

    if (w_load) begin
      case (r_state)
        ST_INIT: begin
          if (r_com_cnt != 2'd3) begin
            w_com_inc = 1'b1;
          end else begin
            // Last preamble byte done; lane_cnt is still 0 here, so the first
            // RUN slot serves lane 0.
            w_state_nxt = ST_RUN;
            w_serve     = 1'b1;
          end
        end
        ST_RUN: begin
          w_serve = 1'b1;
        end
      endcase
    end

    if (w_serve) begin
      w_load_byte            = w_slot_byte;
      w_consume[r_lane_cnt]  = r_full[r_lane_cnt];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_32f) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer datapath and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_32f) begin
    if (rst) begin
      // The COM loaded here is the first of the four preamble characters, and
      // any byte in flight is truncated.
      r_sr       <= COM;
      r_bit_cnt  <= 3'd0;
      r_com_cnt  <= 2'd0;
      r_lane_cnt <= 2'd0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_load) begin
        r_sr <= w_load_byte;
      end else begin
        r_sr <= {r_sr[6:0], 1'b0};
      end
      if (w_com_inc) begin
        r_com_cnt <= r_com_cnt + 2'd1;
      end
      if (w_serve) begin
        r_lane_cnt <= r_lane_cnt + 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lane buffers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_32f) begin
    if (rst) begin
      // NOTE: the byte buffers are cleared along with their full flags; only
      // the flags matter functionally, but clearing both keeps stale lane data
      // from surviving a reset anywhere in the block.
      r_buf  <= '0;
      r_full <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_accept[i]) begin
          r_buf[i]  <= w_data_in[i];
          r_full[i] <= 1'b1;
        end else if (w_consume[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // Outputs
  assign data_out  = r_sr[7];
  assign tx_active = (r_state == ST_RUN);
  assign ready_0   = ~r_full[0];
  assign ready_1   = ~r_full[1];
  assign ready_2   = ~r_full[2];
  assign ready_3   = ~r_full[3];

endmodule
